// File: rtl/cache_line_fill_controller_if.sv
// Signal bundle between the line fill controller and its neighbours: CPU-side
// miss logic, cache data/tag arrays, replacement algorithm and the shared bus.
interface cache_line_fill_controller_if #(
   parameter int COUNTER_WIDTH = 3,
   parameter int TAG_WIDTH     = 8,
   parameter int OFFSET_WIDTH  = 2,
   parameter int DATA_WIDTH    = 16
);
   logic                              missRequest;
   logic [TAG_WIDTH-1:0]              missTag;
   logic [COUNTER_WIDTH-1:0]          replacementCacheLine;
   logic                              lineValid;
   logic                              lineDirty;
   logic [TAG_WIDTH-1:0]              lineTag;
   logic [DATA_WIDTH-1:0]             cacheReadData;
   logic [COUNTER_WIDTH-1:0]          cacheLineIndex;
   logic [OFFSET_WIDTH-1:0]           cacheWordOffset;
   logic                              cacheWriteEnable;
   logic [DATA_WIDTH-1:0]             cacheWriteData;
   logic                              tagWriteEnable;
   logic                              busRequest;
   logic                              busGrant;
   logic                              busRead;
   logic                              busWrite;
   logic [TAG_WIDTH+OFFSET_WIDTH-1:0] busAddress;
   logic [DATA_WIDTH-1:0]             busDataOut;
   logic [DATA_WIDTH-1:0]             busDataIn;
   logic                              busAck;
   logic                              accessEnable;
   logic [COUNTER_WIDTH-1:0]          lastAccessedCacheLine;
   logic                              missDone;

   // Controller side
   modport master (
      input  missRequest, missTag, replacementCacheLine,
             lineValid, lineDirty, lineTag, cacheReadData,
             busGrant, busDataIn, busAck,
      output cacheLineIndex, cacheWordOffset, cacheWriteEnable, cacheWriteData,
             tagWriteEnable, busRequest, busRead, busWrite, busAddress,
             busDataOut, accessEnable, lastAccessedCacheLine, missDone
   );

   // Environment side
   modport slave (
      output missRequest, missTag, replacementCacheLine,
             lineValid, lineDirty, lineTag, cacheReadData,
             busGrant, busDataIn, busAck,
      input  cacheLineIndex, cacheWordOffset, cacheWriteEnable, cacheWriteData,
             tagWriteEnable, busRequest, busRead, busWrite, busAddress,
             busDataOut, accessEnable, lastAccessedCacheLine, missDone
   );
endinterface

// File: rtl/cache_line_fill_controller.sv
// Services one cache miss: optional dirty-victim writeback over the shared bus,
// block fetch into the victim line, tag update and replacement notification.
module cache_line_fill_controller #(
   parameter int NUMBER_OF_CACHE_LINES = 8,
   parameter int COUNTER_WIDTH         = (NUMBER_OF_CACHE_LINES > 1) ? $clog2(NUMBER_OF_CACHE_LINES) : 1,
   parameter int TAG_WIDTH             = 8,
   parameter int OFFSET_WIDTH          = 2,
   parameter int DATA_WIDTH            = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   cache_line_fill_controller_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VICTIM,
      S_ARBITRATE,
      S_WRITEBACK,
      S_FETCH,
      S_UPDATE,
      S_DONE
   } t_state;

   t_state                   r_state;
   logic [OFFSET_WIDTH-1:0]  r_count;
   logic [COUNTER_WIDTH-1:0] r_line;
   logic                     r_victimValid;
   logic                     r_victimDirty;
   logic [TAG_WIDTH-1:0]     r_victimTag;

   logic                     w_lastWord;
   logic                     w_needWriteback;

   assign w_lastWord      = (r_count == '1);
   assign w_needWriteback = r_victimValid && r_victimDirty;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_count       <= '0;
         r_line        <= '0;
         r_victimValid <= 1'b0;
         r_victimDirty <= 1'b0;
         r_victimTag   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.missRequest) begin
                  r_line  <= bus.replacementCacheLine;
                  r_state <= S_VICTIM;
               end
            end
            // Array lookup is addressed by r_line, so the victim's state is valid here
            S_VICTIM: begin
               r_victimValid <= bus.lineValid;
               r_victimDirty <= bus.lineDirty;
               r_victimTag   <= bus.lineTag;
               r_count       <= '0;
               r_state       <= S_ARBITRATE;
            end
            S_ARBITRATE: begin
               if (bus.busGrant) begin
                  r_state <= w_needWriteback ? S_WRITEBACK : S_FETCH;
               end
            end
            S_WRITEBACK: begin
               if (bus.busAck) begin
                  r_count <= r_count + OFFSET_WIDTH'(1);
                  if (w_lastWord) begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (bus.busAck) begin
                  r_count <= r_count + OFFSET_WIDTH'(1);
                  if (w_lastWord) begin
                     r_state <= S_UPDATE;
                  end
               end
            end
            S_UPDATE: begin
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (!bus.missRequest) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Data paths are gated to their transfer state so idle outputs stay at zero
   always_comb begin
      bus.cacheLineIndex        = r_line;
      bus.lastAccessedCacheLine = r_line;
      bus.cacheWordOffset       = r_count;
      bus.cacheWriteEnable      = 1'b0;
      bus.cacheWriteData        = '0;
      bus.tagWriteEnable        = 1'b0;
      bus.busRequest            = 1'b0;
      bus.busRead               = 1'b0;
      bus.busWrite              = 1'b0;
      bus.busAddress            = '0;
      bus.busDataOut            = '0;
      bus.accessEnable          = 1'b0;
      bus.missDone              = 1'b0;
      unique case (r_state)
         S_ARBITRATE: begin
            bus.busRequest = 1'b1;
         end
         S_WRITEBACK: begin
            bus.busRequest = 1'b1;
            bus.busWrite   = 1'b1;
            bus.busAddress = {r_victimTag, r_count};
            bus.busDataOut = bus.cacheReadData;
         end
         S_FETCH: begin
            bus.busRequest       = 1'b1;
            bus.busRead          = 1'b1;
            bus.busAddress       = {bus.missTag, r_count};
            bus.cacheWriteEnable = bus.busAck;
            bus.cacheWriteData   = bus.busDataIn;
         end
         S_UPDATE: begin
            bus.tagWriteEnable = 1'b1;
            bus.accessEnable   = 1'b1;
         end
         S_DONE: begin
            bus.missDone = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_cache_line_fill_controller.sv
// Randomized bench: a per-miss timeline of expected outputs is built from the
// transaction description, then replayed cycle by cycle against the controller.
module tb_cache_line_fill_controller;

   localparam int NL = 8;
   localparam int CW = 3;
   localparam int TW = 8;
   localparam int OW = 2;
   localparam int DW = 16;
   localparam int WORDS = 1 << OW;

   typedef struct {
      logic          rst_n;
      logic          mreq;
      logic [TW-1:0] mtag;
      logic [CW-1:0] repl;
      logic          gnt;
      logic          ack;
      logic [DW-1:0] din;
      logic [CW-1:0] e_idx;
      logic [OW-1:0] e_off;
      logic          e_cwe;
      logic [DW-1:0] e_cwd;
      logic          c_cwd;
      logic          e_twe;
      logic          e_breq;
      logic          e_brd;
      logic          e_bwr;
      logic [TW+OW-1:0] e_addr;
      logic          c_addr;
      logic [DW-1:0] e_bdo;
      logic          c_bdo;
      logic          e_acc;
      logic          e_done;
   } cyc_t;

   logic clk;
   logic rst_n;

   cache_line_fill_controller_if #(
      .COUNTER_WIDTH(CW), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)
   ) ifc ();

   cache_line_fill_controller #(
      .NUMBER_OF_CACHE_LINES(NL), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (ifc.master)
   );

   // Static cache array contents seen by the controller
   logic          env_valid [NL];
   logic          env_dirty [NL];
   logic [TW-1:0] env_tag   [NL];
   logic [DW-1:0] env_data  [NL][WORDS];

   assign ifc.lineValid     = env_valid[ifc.cacheLineIndex];
   assign ifc.lineDirty     = env_dirty[ifc.cacheLineIndex];
   assign ifc.lineTag       = env_tag[ifc.cacheLineIndex];
   assign ifc.cacheReadData = env_data[ifc.cacheLineIndex][ifc.cacheWordOffset];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cyc_t          plan [$];
   logic [CW-1:0] m_line;
   logic          m_fresh;
   int            n_vec;
   int            n_err;

   task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL cycle %0d %s: got %0h expected %0h", k, nm, act, exp);
      end
   endtask

   function automatic cyc_t idle_rec();
      cyc_t c;
      c.rst_n  = 1'b1;
      c.mreq   = 1'b0;
      c.mtag   = TW'($urandom);
      c.repl   = CW'($urandom);
      c.gnt    = 1'($urandom);
      c.ack    = 1'($urandom);
      c.din    = DW'($urandom);
      c.e_idx  = m_line;
      c.e_off  = '0;
      c.e_cwe  = 1'b0;
      c.e_cwd  = '0;
      c.c_cwd  = m_fresh;
      c.e_twe  = 1'b0;
      c.e_breq = 1'b0;
      c.e_brd  = 1'b0;
      c.e_bwr  = 1'b0;
      c.e_addr = '0;
      c.c_addr = m_fresh;
      c.e_bdo  = '0;
      c.c_bdo  = m_fresh;
      c.e_acc  = 1'b0;
      c.e_done = 1'b0;
      return c;
   endfunction

   function automatic cyc_t busy_rec(input logic [TW-1:0] t);
      cyc_t c;
      c = idle_rec();
      c.mreq = 1'b1;
      c.mtag = t;
      return c;
   endfunction

   task automatic add_reset();
      cyc_t c;
      m_line  = '0;
      m_fresh = 1'b1;
      c = idle_rec();
      c.rst_n = 1'b0;
      plan.push_back(c);
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) plan.push_back(idle_rec());
   endtask

   // Expected timeline of one miss; abort >= 0 asserts reset after that many fetch acks
   task automatic add_miss(input logic [CW-1:0] v, input logic [TW-1:0] t, input int g,
                           input int smin, input int smax, input int hold, input int abort);
      cyc_t c;
      int   st;
      c = busy_rec(t);
      c.repl = v;
      plan.push_back(c);
      m_line  = v;
      m_fresh = 1'b0;
      plan.push_back(busy_rec(t));
      for (int i = 0; i <= g; i++) begin
         c = busy_rec(t);
         c.gnt    = (i == g);
         c.e_breq = 1'b1;
         plan.push_back(c);
      end
      if (env_valid[v] && env_dirty[v]) begin
         for (int w = 0; w < WORDS; w++) begin
            st = int'($urandom_range(smax, smin));
            for (int s = 0; s <= st; s++) begin
               c = busy_rec(t);
               c.gnt    = 1'b1;
               c.ack    = (s == st);
               c.e_breq = 1'b1;
               c.e_bwr  = 1'b1;
               c.e_off  = OW'(w);
               c.e_addr = {env_tag[v], OW'(w)};
               c.c_addr = 1'b1;
               c.e_bdo  = env_data[v][w];
               c.c_bdo  = 1'b1;
               plan.push_back(c);
            end
         end
      end
      for (int w = 0; w < WORDS; w++) begin
         if (w == abort) begin
            add_reset();
            return;
         end
         st = int'($urandom_range(smax, smin));
         for (int s = 0; s <= st; s++) begin
            c = busy_rec(t);
            c.gnt    = 1'b1;
            c.ack    = (s == st);
            c.e_breq = 1'b1;
            c.e_brd  = 1'b1;
            c.e_off  = OW'(w);
            c.e_addr = {t, OW'(w)};
            c.c_addr = 1'b1;
            c.e_cwe  = (s == st);
            c.e_cwd  = c.din;
            c.c_cwd  = 1'b1;
            plan.push_back(c);
         end
      end
      c = busy_rec(t);
      c.e_twe = 1'b1;
      c.e_acc = 1'b1;
      plan.push_back(c);
      for (int i = 0; i < hold; i++) begin
         c = busy_rec(t);
         c.e_done = 1'b1;
         plan.push_back(c);
      end
      c = idle_rec();
      c.e_done = 1'b1;
      plan.push_back(c);
   endtask

   initial begin
      int s;
      n_vec = 0;
      n_err = 0;
      m_line  = '0;
      m_fresh = 1'b1;
      rst_n = 1'b0;
      ifc.missRequest = 1'b0;
      ifc.missTag = '0;
      ifc.replacementCacheLine = '0;
      ifc.busGrant = 1'b0;
      ifc.busAck = 1'b0;
      ifc.busDataIn = '0;

      for (int i = 0; i < NL; i++) begin
         env_valid[i] = 1'($urandom);
         env_dirty[i] = 1'($urandom);
         env_tag[i]   = TW'($urandom);
         for (int w = 0; w < WORDS; w++) env_data[i][w] = DW'($urandom);
      end
      env_valid[5] = 1'b1; env_dirty[5] = 1'b0;
      env_valid[2] = 1'b1; env_dirty[2] = 1'b1; env_tag[2] = 8'h11;
      env_valid[6] = 1'b0; env_dirty[6] = 1'b1;

      add_reset();
      add_reset();
      add_idle(3);

      // Clean victim, immediate grant, ack every cycle
      s = plan.size();
      add_miss(3'd5, 8'h3A, 0, 0, 0, 1, -1);
      chk(-1, "model_clean_addr_c3", 32'(plan[s+3].e_addr), 32'h0E8);
      chk(-1, "model_clean_addr_c6", 32'(plan[s+6].e_addr), 32'h0EB);
      chk(-1, "model_clean_upd_c7", {30'd0, plan[s+7].e_twe, plan[s+7].e_acc}, 32'h3);
      chk(-1, "model_clean_done_c8", 32'(plan[s+8].e_done), 32'h1);
      add_idle(2);

      // Dirty victim
      s = plan.size();
      add_miss(3'd2, 8'h22, 0, 0, 0, 1, -1);
      chk(-1, "model_dirty_wb_addr", 32'(plan[s+3].e_addr), 32'h044);
      chk(-1, "model_dirty_rd_addr", 32'(plan[s+7].e_addr), 32'h088);
      add_idle(1);

      // Grant delayed 3 cycles, ack every other cycle
      add_miss(3'd5, 8'h77, 3, 1, 1, 1, -1);
      add_idle(2);

      // Requester holds missRequest after completion
      add_miss(3'd3, 8'hC4, 1, 0, 1, 4, -1);
      add_idle(1);

      // Invalid but dirty victim goes straight to fetch
      s = plan.size();
      add_miss(3'd6, 8'h5C, 0, 0, 0, 1, -1);
      chk(-1, "model_invalid_fetch", {30'd0, plan[s+3].e_brd, plan[s+3].e_bwr}, 32'h2);
      add_idle(1);

      // Reset two acks into the fetch, then restart
      add_miss(3'd2, 8'h99, 1, 0, 1, 1, 2);
      add_reset();
      add_idle(2);
      add_miss(3'd4, 8'hA5, 0, 0, 0, 1, -1);

      for (int m = 0; m < 40; m++) begin
         add_idle(int'($urandom_range(3, 0)));
         add_miss(CW'($urandom), TW'($urandom), int'($urandom_range(3, 0)), 0,
                  int'($urandom_range(2, 0)), int'($urandom_range(4, 1)), -1);
      end
      add_idle(3);

      for (int k = 0; k < plan.size(); k++) begin
         @(posedge clk);
         #1;
         rst_n                    = plan[k].rst_n;
         ifc.missRequest          = plan[k].mreq;
         ifc.missTag              = plan[k].mtag;
         ifc.replacementCacheLine = plan[k].repl;
         ifc.busGrant             = plan[k].gnt;
         ifc.busAck               = plan[k].ack;
         ifc.busDataIn            = plan[k].din;
         @(negedge clk);
         chk(k, "cacheLineIndex", 32'(ifc.cacheLineIndex), 32'(plan[k].e_idx));
         chk(k, "lastAccessedCacheLine", 32'(ifc.lastAccessedCacheLine), 32'(plan[k].e_idx));
         chk(k, "cacheWordOffset", 32'(ifc.cacheWordOffset), 32'(plan[k].e_off));
         chk(k, "cacheWriteEnable", 32'(ifc.cacheWriteEnable), 32'(plan[k].e_cwe));
         chk(k, "tagWriteEnable", 32'(ifc.tagWriteEnable), 32'(plan[k].e_twe));
         chk(k, "busRequest", 32'(ifc.busRequest), 32'(plan[k].e_breq));
         chk(k, "busRead", 32'(ifc.busRead), 32'(plan[k].e_brd));
         chk(k, "busWrite", 32'(ifc.busWrite), 32'(plan[k].e_bwr));
         chk(k, "accessEnable", 32'(ifc.accessEnable), 32'(plan[k].e_acc));
         chk(k, "missDone", 32'(ifc.missDone), 32'(plan[k].e_done));
         if (plan[k].c_addr) chk(k, "busAddress", 32'(ifc.busAddress), 32'(plan[k].e_addr));
         if (plan[k].c_cwd)  chk(k, "cacheWriteData", 32'(ifc.cacheWriteData), 32'(plan[k].e_cwd));
         if (plan[k].c_bdo)  chk(k, "busDataOut", 32'(ifc.busDataOut), 32'(plan[k].e_bdo));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_line_fill_controller.md
# cache_line_fill_controller

Sequences a cache-unit miss in the snoopy invalidate-protocol cache. It takes the victim line chosen by the replacement algorithm, writes the victim back over the shared bus if it is dirty, and fetches the missing block into that line. It then updates the line's tag and state and reports the access back to the replacement algorithm. It sits between the CPU-side miss logic, the cache data/tag arrays, the replacement algorithm slave port and the shared bus.

## Interface
Parameters:
- NUMBER_OF_CACHE_LINES, 8, lines in the cache.
- COUNTER_WIDTH, ceil(log2(NUMBER_OF_CACHE_LINES)) with a minimum of 1, line index width.
- TAG_WIDTH, 8, tag bits.
- OFFSET_WIDTH, 2, word-offset bits; a line holds 2^OFFSET_WIDTH words.
- DATA_WIDTH, 16, word width.

Ports (clock, reset first):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- missRequest  in  1  miss pending; held high until missDone.
- missTag  in  TAG_WIDTH  tag of missing block; stable while missRequest is high.
- replacementCacheLine  in  COUNTER_WIDTH  victim from the replacement algorithm.
- lineValid, lineDirty  in  1 each  state of line cacheLineIndex (combinational lookup).
- lineTag  in  TAG_WIDTH  tag of line cacheLineIndex.
- cacheReadData  in  DATA_WIDTH  data word at cacheLineIndex/cacheWordOffset.
- cacheLineIndex  out  COUNTER_WIDTH  line being filled (registered).
- cacheWordOffset  out  OFFSET_WIDTH  word counter.
- cacheWriteEnable  out  1  write cacheWriteData into the data array.
- cacheWriteData  out  DATA_WIDTH  equals busDataIn.
- tagWriteEnable  out  1  write missTag, set valid, clear dirty.
- busRequest  out  1  shared-bus request.
- busGrant  in  1  grant; the arbiter holds it until busRequest drops.
- busRead, busWrite  out  1 each  bus command.
- busAddress  out  TAG_WIDTH+OFFSET_WIDTH  {tag, word offset}.
- busDataOut  out  DATA_WIDTH  equals cacheReadData.
- busDataIn  in  DATA_WIDTH  fetched word.
- busAck  in  1  current word transferred.
- accessEnable  out  1  one-cycle pulse to the replacement algorithm.
- lastAccessedCacheLine  out  COUNTER_WIDTH  equals cacheLineIndex.
- missDone  out  1  completion (4-phase).

## Operation
- States: IDLE, VICTIM, ARBITRATE, WRITEBACK, FETCH, UPDATE, DONE.
- IDLE: on missRequest=1, load replacementCacheLine into cacheLineIndex and go to VICTIM.
- VICTIM (1 cycle): latch lineValid, lineDirty and lineTag for the victim; clear the word counter; go to ARBITRATE.
- ARBITRATE: busRequest=1. When busGrant=1, go to WRITEBACK if the latched victim is valid and dirty, else go to FETCH.
- busRequest stays 1 through WRITEBACK and FETCH and drops on entry to UPDATE.
- WRITEBACK: busWrite=1, busAddress={latched lineTag, counter}. Each busAck increments the counter. The ack at counter 2^OFFSET_WIDTH-1 wraps the counter to 0 and moves to FETCH without releasing the bus.
- FETCH: busRead=1, busAddress={missTag, counter}. On busAck, cacheWriteEnable=1 at cacheWordOffset=counter and the counter increments. The final ack wraps the counter and moves to UPDATE.
- UPDATE (1 cycle): tagWriteEnable=1, accessEnable=1; then go to DONE.
- DONE: missDone=1 until missRequest=0, then go to IDLE. missDone drops in the same cycle the FSM returns to IDLE.
- busAck outside WRITEBACK/FETCH is ignored. busGrant outside ARBITRATE is ignored.
- An invalid victim, or a valid clean victim, skips WRITEBACK.

## Timing
- Reset (asynchronous, any state): FSM to IDLE, counter 0, cacheLineIndex 0, latched victim state 0.
- Every output is 0 during and after reset until the next miss. No partial array or tag write occurs.
- Output decode is combinational from the registered state, counter and latches. No output depends combinationally on missRequest.
- Minimum latency, with a clean victim, grant in the first ARBITRATE cycle and busAck every cycle: missRequest seen at edge 0, VICTIM 1, ARBITRATE 2, FETCH 3–6, UPDATE 7, missDone first high in cycle 8.
- A dirty victim adds 2^OFFSET_WIDTH WRITEBACK cycles.
- Bus stalls (busAck=0) hold the state, counter and address unchanged.

## Test plan
- Reset mid-FETCH, after 2 acks -> all outputs 0 immediately. After release, a new miss restarts at VICTIM with the counter at 0.
- Clean-victim miss (replacementCacheLine=5, lineValid=1, lineDirty=0, missTag=0x3A, immediate grant, acks every cycle) -> busRead addresses 0xE8..0xEB in cycles 3–6, four cacheWriteEnable pulses, tagWriteEnable and accessEnable with lastAccessedCacheLine=5 in cycle 7, missDone in cycle 8.
- Dirty victim (lineTag=0x11, missTag=0x22) -> busWrite addresses 0x44..0x47 with busDataOut=cacheReadData, then busRead 0x88..0x8B. busRequest stays high throughout.
- Grant delayed 3 cycles and busAck withheld every other cycle -> busRequest stays 1, no read or write before grant, each word takes 2 cycles, no extra cacheWriteEnable pulses.
- missRequest held 4 cycles after missDone -> missDone held 4 cycles, no second fill, FSM returns to IDLE in the cycle missRequest drops.
- Invalid victim with lineDirty=1 -> WRITEBACK is skipped.
